// File: rtl/cmp_seq.sv
// ---------------------------------------------------------------------------
// cmp_seq
//   Sequential magnitude comparator. A and B are latched when start is
//   accepted. The comparison then walks CHUNK-bit slices from the MSB end,
//   one slice per cycle, and stops at the first slice that differs. Signed
//   compares invert the sign bit of both operands in the top slice, which
//   turns a two's-complement ordering into a plain unsigned ordering.
//
// Parameters
//   WIDTH       operand width in bits (>= 1)
//   CHUNK       bits compared per cycle (WIDTH % CHUNK == 0)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   start       request a compare (only honoured in IDLE)
//   signed_mode 1 = two's-complement compare, 0 = unsigned
//   a, b        operands, latched on an accepted start
//   busy        high while slices are being compared
//   done        one-cycle pulse, result valid
//   gt, eq, lt  result flags, held until the next accepted start
// ---------------------------------------------------------------------------
module cmp_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic             sign_lat;
    logic [KW-1:0]    k;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             last_chunk;

    // Pick the slice selected by k with a constant-index mux, so every
    // select stays static. Slice 0 is the MSB slice; in signed mode its top
    // bit (the sign bit) is inverted on both sides before the unsigned compare.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                a_chunk = a_lat[WIDTH-1-i*CHUNK -: CHUNK];
                b_chunk = b_lat[WIDTH-1-i*CHUNK -: CHUNK];
            end
        end
        if (sign_lat && (k == '0)) begin
            a_chunk[CHUNK-1] = ~a_chunk[CHUNK-1];
            b_chunk[CHUNK-1] = ~b_chunk[CHUNK-1];
        end
        last_chunk = (k == KW'(N - 1));
    end

    // Control FSM with registered outputs. busy is asserted on entry to RUN
    // and dropped on the transition to DONE, so it is high only in RUN
    // cycles. Reset wins over everything and silently abandons a compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_lat    <= '0;
            b_lat    <= '0;
            sign_lat <= 1'b0;
            k        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_lat    <= a;
                        b_lat    <= b;
                        sign_lat <= signed_mode;
                        k        <= '0;
                        gt       <= 1'b0;
                        eq       <= 1'b0;
                        lt       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (a_chunk > b_chunk) begin
                        gt    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (a_chunk < b_chunk) begin
                        lt    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (last_chunk) begin
                        eq    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_seq.sv
// ---------------------------------------------------------------------------
// tb_cmp_seq
//   Scoreboard bench for cmp_seq at WIDTH=8, CHUNK=4. Each accepted start
//   pushes the expected flags and the cycle in which done must appear; a
//   monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_cmp_seq;

    localparam int WIDTH = 8;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             clk;
    logic             reset;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   doneCycle;
    } expT;

    expT sbQ[$];
    expT lastExp;
    int  cycleCount;
    int  checkCount;
    int  errorCount;

    cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_mode(signed_mode),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .gt         (gt),
        .eq         (eq),
        .lt         (lt)
    );

    // Free-running clock plus a cycle counter so latencies can be checked
    // as absolute cycle numbers.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cycleCount = 0;
    always @(posedge clk) cycleCount = cycleCount + 1;

    // Hard stop in case something wedges the main sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: signed/unsigned ordering from native comparisons; latency
    // from the first slice (MSB first) where the raw operands differ.
    function automatic expT computeExpected(input logic [WIDTH-1:0] av,
                                            input logic [WIDTH-1:0] bv,
                                            input logic sm, input int t);
        expT e;
        int  firstDiff;
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb;
        if (sm) begin
            e.gt = ($signed(av) > $signed(bv));
            e.lt = ($signed(av) < $signed(bv));
        end else begin
            e.gt = (av > bv);
            e.lt = (av < bv);
        end
        e.eq = (av == bv);
        firstDiff = -1;
        for (int c = 0; c < N; c++) begin
            sa = av >> (WIDTH - (c + 1) * CHUNK);
            sb = bv >> (WIDTH - (c + 1) * CHUNK);
            if (firstDiff < 0 && (sa[CHUNK-1:0] != sb[CHUNK-1:0])) firstDiff = c;
        end
        e.doneCycle = (firstDiff < 0) ? (t + 1 + N) : (t + 2 + firstDiff);
        return e;
    endfunction

    // Called at a negedge with the DUT idle: drives one start for a single
    // cycle and records what must come out. Returns at the next negedge.
    task automatic applyStimulus(input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv, input logic sm);
        a           = av;
        b           = bv;
        signed_mode = sm;
        start       = 1'b1;
        sbQ.push_back(computeExpected(av, bv, sm, cycleCount));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for the scoreboard to drain, then one more cycle so the
    // DUT is back in IDLE.
    task automatic waitIdle();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            checkOutput("doneTimeout", sbQ.size(), 0);
            sbQ.delete();
        end
        @(negedge clk);
    endtask

    task automatic holdCheck();
        repeat (3) @(negedge clk);
        checkOutput("holdGt", gt, lastExp.gt);
        checkOutput("holdEq", eq, lastExp.eq);
        checkOutput("holdLt", lt, lastExp.lt);
    endtask

    // Monitor: every done pulse must match the oldest expectation, arrive
    // in the predicted cycle and carry a one-hot result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedDone", 1, 0);
            end else begin
                lastExp = sbQ.pop_front();
                checkOutput("doneCycle", cycleCount, lastExp.doneCycle);
                checkOutput("gt", gt, lastExp.gt);
                checkOutput("eq", eq, lastExp.eq);
                checkOutput("lt", lt, lastExp.lt);
                checkOutput("busyInDone", busy, 0);
                checkOutput("oneHot", {29'd0, gt, eq, lt} == 32'd1 ||
                                      {29'd0, gt, eq, lt} == 32'd2 ||
                                      {29'd0, gt, eq, lt} == 32'd4, 1);
            end
        end
    end

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstFlags", {29'd0, gt, eq, lt}, 0);

        // Start in the very first cycle with reset low; equal operands.
        reset = 1'b0;
        applyStimulus(8'h00, 8'h00, 1'b0);
        checkOutput("eqBusyT1", busy, 1);
        @(negedge clk);
        checkOutput("eqBusyT2", busy, 1);
        @(negedge clk);
        // DONE cycle: a start here must be ignored.
        a     = 8'h55;
        b     = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignoreInDone", busy, 0);
        waitIdle();
        holdCheck();

        // Early exit in the first slice.
        @(negedge clk);
        applyStimulus(8'hA0, 8'h30, 1'b0);
        checkOutput("earlyBusyT1", busy, 1);
        @(negedge clk);
        checkOutput("earlyBusyT2", busy, 0);
        waitIdle();

        // Sign mode flips the ordering of 0x80 vs 0x7F.
        @(negedge clk);
        applyStimulus(8'h80, 8'h7F, 1'b1);
        waitIdle();
        applyStimulus(8'h80, 8'h7F, 1'b0);
        waitIdle();

        // Difference only in the last slice.
        applyStimulus(8'h35, 8'h37, 1'b0);
        waitIdle();
        holdCheck();

        // Start while busy is ignored; operand changes mid-run too.
        @(negedge clk);
        applyStimulus(8'h10, 8'h20, 1'b0);
        a     = 8'hFF;
        b     = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle();
        repeat (4) @(negedge clk);

        // Abort by reset in t+1: no done, flags cleared, then a clean run.
        applyStimulus(8'h00, 8'h00, 1'b0);
        reset = 1'b1;
        sbQ.delete();
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortFlags", {29'd0, gt, eq, lt}, 0);
        repeat (4) @(negedge clk);
        applyStimulus(8'hC3, 8'hC3, 1'b1);
        waitIdle();

        // Random compares with operand noise and stray starts during RUN.
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra;
            else if ($urandom_range(0, 2) == 0) rb = {ra[7:4], rb[3:0]};
            applyStimulus(ra, rb, 1'($urandom));
            a           = 8'($urandom);
            b           = 8'($urandom);
            signed_mode = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            waitIdle();
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cmp_seq.md
CMP_SEQ -- requirements
Module: cmp_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal: WIDTH >= 1).
REQ-002 The block SHALL have parameter CHUNK, default 4, giving bits compared per cycle (legal: 1 <= CHUNK <= WIDTH, WIDTH % CHUNK == 0); N = WIDTH/CHUNK.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a comparison; sampled only in IDLE.
REQ-007 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with operands.
REQ-008 a  input  WIDTH  operand A; latched on accepted start.
REQ-009 b  input  WIDTH  operand B; latched on accepted start.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 gt / eq / lt  output  1 each  A>B / A==B / A<B.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at the edge SHALL latch a, b and signed_mode, clear gt/eq/lt to 0, set chunk index k=0 (MSB chunk) and go to RUN; start=0 stays IDLE.
REQ-015 RUN: each cycle SHALL compare latched chunk k (bits WIDTH-1-k*CHUNK down to WIDTH-(k+1)*CHUNK) of A against B, unsigned.
REQ-016 In signed_mode, the compare of chunk 0 SHALL invert bit WIDTH-1 of both operands; other chunks compare unchanged.
REQ-017 Chunk differs: SHALL register gt or lt accordingly and go to DONE (early exit); remaining chunks are not examined.
REQ-018 Chunk equal and k < N-1: SHALL increment k and stay in RUN.
REQ-019 Chunk equal and k == N-1: SHALL register eq=1 and go to DONE.
REQ-020 DONE: done SHALL be 1 for exactly this one cycle, then go to IDLE unconditionally.
REQ-021 Latency: start accepted at edge of cycle t, difference in chunk i -> done=1 in cycle t+2+i; worst case (equal, or difference in last chunk) done in cycle t+1+N.
REQ-022 busy SHALL be 1 exactly in the RUN cycles, and 0 in IDLE and DONE.
REQ-023 After done, exactly one of gt/eq/lt SHALL be 1; that value SHALL hold until the next accepted start.
REQ-024 start in RUN or DONE SHALL be ignored (no re-latch, no queuing); a, b and signed_mode changes outside an accepted start SHALL not affect the result.
REQ-025 WIDTH=1, CHUNK=1 SHALL behave as a single-bit compare with done in cycle t+2.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, k=0, busy=0, done=0, gt=eq=lt=0, and clear the latched operands to 0.
REQ-027 reset SHALL take priority over start and over any in-flight comparison; an aborted compare SHALL produce no done pulse.
REQ-028 After reset deassertion, the first start SHALL be acceptable in the first cycle with reset low.

Verification (WIDTH=8, CHUNK=4, N=2; start accepted at edge of cycle t)
REQ-029 Equal case: unsigned a=0x00, b=0x00 -> busy in t+1..t+2, done=1 in t+3, eq=1, gt=lt=0.
REQ-030 Early exit: unsigned a=0xA0, b=0x30 -> done=1 in t+2, gt=1; busy high for one cycle only.
REQ-031 Sign mode: a=0x80, b=0x7F with signed_mode=1 -> lt=1; same operands with signed_mode=0 -> gt=1.
REQ-032 Last-chunk difference: unsigned a=0x35, b=0x37 -> done=1 in t+3, lt=1.
REQ-033 Start while busy: start with a=0x10, b=0x20, then start with a=0xFF, b=0x00 in t+1 -> single done, lt=1, no second run.
REQ-034 Abort: reset=1 in t+1 of a compare -> in t+2 busy=0, gt=eq=lt=0; no done; the next start completes normally.
